// File: rtl/tdm_mux_scan_pkg.sv
// tdm_mux_scan_pkg: shared mode encodings and width helper for the TDM mux
package tdm_mux_scan_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/tdm_mux_scan_next.sv
// scan_next: next enabled channel above cur, wrapping, with wrap and none-enabled flags
module scan_next #(
  parameter int CH = 4,
  parameter int SELW = 2
) (
  input  logic [SELW-1:0] cur,
  input  logic [CH-1:0]   ch_mask,
  output logic [SELW-1:0] nxt,
  output logic            wrapped,
  output logic            none_en
);
  logic [SELW:0] raw;
  logic [SELW:0] idx;
  logic wr;
  logic found;
  assign none_en = ~|ch_mask;
  always_comb begin
    nxt = cur;
    wrapped = 1'b0;
    found = 1'b0;
    raw = '0;
    idx = '0;
    wr = 1'b0;
    for (int i = 1; i <= CH; i++) begin
      raw = {1'b0, cur} + (SELW+1)'(i);
      wr = raw >= (SELW+1)'(CH);
      idx = wr ? raw - (SELW+1)'(CH) : raw;
      if (!found && ch_mask[idx[SELW-1:0]]) begin
        found = 1'b1;
        nxt = idx[SELW-1:0];
        wrapped = wr;
      end
    end
  end
endmodule

// File: rtl/tdm_mux_scan.sv
// tdm_mux_scan: registered CH:1 TDM mux with manual select and masked auto-scan
module tdm_mux_scan
  import tdm_mux_scan_pkg::*;
#(
  parameter int CH = 4,
  parameter int W = 1,
  parameter int DWELL = 1,
  parameter int SELW = clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SELW-1:0] sel_in,
  input  logic [CH-1:0]   ch_mask,
  input  logic [CH*W-1:0] din,
  output logic [W-1:0]    dout,
  output logic [SELW-1:0] sel_out,
  output logic            valid,
  output logic            frame_start
);
  localparam int DW = clog2(DWELL + 1);
  logic [DW-1:0] dwell_cnt;
  logic [DW-1:0] cnt_nxt;
  logic [SELW-1:0] sel_nxt;
  logic [SELW-1:0] scan_nxt;
  logic wrapped;
  logic none_en;
  logic sel_ok;
  logic adv;
  logic valid_nxt;
  logic fs_nxt;
  scan_next #(.CH(CH), .SELW(SELW)) u_scan (
    .cur(sel_out),
    .ch_mask(ch_mask),
    .nxt(scan_nxt),
    .wrapped(wrapped),
    .none_en(none_en)
  );
  always_comb begin
    sel_ok = {1'b0, sel_in} < (SELW+1)'(CH);
    adv = (dwell_cnt == DW'(DWELL - 1)) || !ch_mask[sel_out];
    sel_nxt = !en ? sel_out :
              mode == MODE_MANUAL ? (sel_ok ? sel_in : sel_out) :
              (!none_en && adv) ? scan_nxt : sel_out;
    cnt_nxt = !en ? dwell_cnt :
              (mode == MODE_MANUAL || none_en || adv) ? '0 : dwell_cnt + DW'(1);
    valid_nxt = en && (mode == MODE_MANUAL ? sel_ok : !none_en);
    fs_nxt = en && mode == MODE_SCAN && !none_en && adv && wrapped;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      sel_out <= '0;
      dwell_cnt <= '0;
      valid <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sel_out <= sel_nxt;
      dwell_cnt <= cnt_nxt;
      valid <= valid_nxt;
      frame_start <= fs_nxt;
      if (en) dout <= din[sel_nxt*W +: W];
    end
  end
endmodule
